// File: rtl/ee357_alu_pkg.sv
// Shared encodings for the ee357 R-type execute stage: opcode/funct values,
// FSM states and flag-vector bit positions.
package ee357_alu_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_XOR = 6'b100110;
  localparam logic [5:0] FUNC_NOR = 6'b100111;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_SLL = 6'b000000;
  localparam logic [5:0] FUNC_SRL = 6'b000010;
  localparam logic [5:0] FUNC_SRA = 6'b000011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned FLAG_UOV  = 3;
  localparam int unsigned FLAG_SOV  = 2;
  localparam int unsigned FLAG_ZERO = 1;
  localparam int unsigned FLAG_COUT = 0;

  function automatic logic is_shift(input logic [5:0] funct);
    return (funct == FUNC_SLL) || (funct == FUNC_SRL) || (funct == FUNC_SRA);
  endfunction

  function automatic logic is_legal_funct(input logic [5:0] funct);
    return (funct == FUNC_ADD) || (funct == FUNC_SUB) || (funct == FUNC_AND) ||
           (funct == FUNC_OR)  || (funct == FUNC_XOR) || (funct == FUNC_NOR) ||
           (funct == FUNC_SLT) || is_shift(funct)     || (funct == FUNC_JR);
  endfunction

endpackage

// File: rtl/ee357_alu.sv
// Combinational 32-bit ALU selected by the R-type funct field. Shifts move b
// by a[4:0]; carry/overflow flags are only meaningful for ADD and SUB.
module ee357_alu
  import ee357_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  func,
  output logic [31:0] res,
  output logic        uov,
  output logic        sov,
  output logic        zero,
  output logic        cout
);

  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Subtraction as a + ~b + 1: carry out set means no borrow.
  assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    res  = '0;
    uov  = 1'b0;
    sov  = 1'b0;
    cout = 1'b0;
    case (func)
      FUNC_ADD: begin
        res  = sum[31:0];
        cout = sum[32];
        uov  = sum[32];
        sov  = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      FUNC_SUB: begin
        res  = diff[31:0];
        cout = diff[32];
        uov  = ~diff[32];
        sov  = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      FUNC_AND: res = a & b;
      FUNC_OR:  res = a | b;
      FUNC_XOR: res = a ^ b;
      FUNC_NOR: res = ~(a | b);
      FUNC_SLT: res = {31'b0, ($signed(a) < $signed(b))};
      FUNC_SLL: res = b << a[4:0];
      FUNC_SRL: res = b >> a[4:0];
      FUNC_SRA: res = 32'($signed(b) >>> a[4:0]);
      default:  res = '0;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/ee357_alu_exec.sv
// R-type execute stage: latch an instruction and operands, evaluate through
// ee357_alu, and hold a registered result until write-back accepts it.
module ee357_alu_exec
  import ee357_alu_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned RA = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [W-1:0]  rs_val,
  input  logic [W-1:0]  rt_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_res,
  output logic [RA-1:0] out_rd,
  output logic          out_we,
  output logic [3:0]    out_flags,
  output logic          ovf_exc,
  output logic          illegal
);

  state_e state_q, state_d;

  logic [5:0]    opc_q, funct_q;
  logic [4:0]    shamt_q;
  logic [RA-1:0] rd_q;
  logic [W-1:0]  rs_q, rt_q;

  logic [W-1:0]  res_q, res_d;
  logic [RA-1:0] ord_q, ord_d;
  logic          we_q, we_d;
  logic [3:0]    flags_q, flags_d;
  logic          ovf_q, ovf_d;
  logic          ill_q, ill_d;

  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_res;
  logic          alu_uov, alu_sov, alu_zero, alu_cout;
  logic [3:0]    alu_flags;
  logic          legal, is_jr, is_arith, accept;

  // rs/rt register numbers are resolved upstream.
  logic unused_instr;
  assign unused_instr = ^instr[25:16];

  assign accept    = (state_q == StIdle) && in_valid;
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign ovf_exc   = out_valid && ovf_q;
  assign illegal   = out_valid && ill_q;
  assign out_res   = res_q;
  assign out_rd    = ord_q;
  assign out_we    = we_q;
  assign out_flags = flags_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign alu_a = is_shift(funct_q) ? {{(W-5){1'b0}}, shamt_q} : rs_q;

  ee357_alu u_alu (
    .a    (alu_a),
    .b    (rt_q),
    .func (funct_q),
    .res  (alu_res),
    .uov  (alu_uov),
    .sov  (alu_sov),
    .zero (alu_zero),
    .cout (alu_cout)
  );

  always_comb begin
    alu_flags            = '0;
    alu_flags[FLAG_UOV]  = alu_uov;
    alu_flags[FLAG_SOV]  = alu_sov;
    alu_flags[FLAG_ZERO] = alu_zero;
    alu_flags[FLAG_COUT] = alu_cout;

    legal    = (opc_q == OPC_RTYPE) && is_legal_funct(funct_q);
    is_jr    = (funct_q == FUNC_JR);
    is_arith = (funct_q == FUNC_ADD) || (funct_q == FUNC_SUB);

    res_d   = alu_res;
    flags_d = alu_flags;
    ord_d   = rd_q;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    if (!legal) begin
      res_d   = '0;
      flags_d = '0;
      ill_d   = 1'b1;
    end else if (is_jr) begin
      res_d   = rs_q;
      flags_d = '0;
      ord_d   = '0;
    end else begin
      ovf_d = is_arith && alu_sov;
    end
    // $zero is never written; traps and JR suppress the write too.
    we_d = legal && !is_jr && !ovf_d && (rd_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      opc_q   <= '0;
      funct_q <= '0;
      shamt_q <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      res_q   <= '0;
      ord_q   <= '0;
      we_q    <= 1'b0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opc_q   <= instr[31:26];
        rd_q    <= instr[15:11];
        shamt_q <= instr[10:6];
        funct_q <= instr[5:0];
        rs_q    <= rs_val;
        rt_q    <= rt_val;
      end
      if (state_q == StExec) begin
        res_q   <= res_d;
        ord_q   <= ord_d;
        we_q    <= we_d;
        flags_q <= flags_d;
        ovf_q   <= ovf_d;
        ill_q   <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_ee357_alu_exec.sv
// Bench for ee357_alu_exec: directed cases plus random R-type traffic checked
// against an arithmetic reference model.
module tb_ee357_alu_exec;
  import ee357_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [3:0]  out_flags;
  logic        ovf_exc;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic [3:0]  flags;
    logic        ovf;
    logic        ill;
  } exp_t;

  ee357_alu_exec #(.W(32), .RA(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_rd    (out_rd),
    .out_we    (out_we),
    .out_flags (out_flags),
    .ovf_exc   (ovf_exc),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural rules.
  function automatic exp_t model(input logic [31:0] iw, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [5:0]  op, f;
    logic [4:0]  rd, sh;
    longint      s;
    logic        uov, sov, cout;
    op = iw[31:26]; f = iw[5:0]; rd = iw[15:11]; sh = iw[10:6];
    e = '0; e.rd = rd; uov = 0; sov = 0; cout = 0;
    if (op != 6'd0 || !(f inside {FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR,
                                  FUNC_SLT, FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_JR})) begin
      e.ill = 1'b1;
      return e;
    end
    if (f == FUNC_JR) begin
      e.res = a;
      e.rd  = 5'd0;
      return e;
    end
    case (f)
      FUNC_ADD: begin
        s     = longint'({32'b0, a}) + longint'({32'b0, b});
        e.res = a + b;
        cout  = (s > 64'sd4294967295);
        uov   = cout;
        s     = longint'($signed(a)) + longint'($signed(b));
        sov   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      FUNC_SUB: begin
        e.res = a - b;
        cout  = (a >= b);
        uov   = (a < b);
        s     = longint'($signed(a)) - longint'($signed(b));
        sov   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      FUNC_AND: e.res = a & b;
      FUNC_OR:  e.res = a | b;
      FUNC_XOR: e.res = a ^ b;
      FUNC_NOR: e.res = ~(a | b);
      FUNC_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      FUNC_SLL: e.res = b << sh;
      FUNC_SRL: e.res = b >> sh;
      default:  e.res = $signed(b) >>> sh;
    endcase
    e.flags = {uov, sov, (e.res == 32'd0), cout};
    e.ovf   = ((f == FUNC_ADD) || (f == FUNC_SUB)) && sov;
    e.we    = !e.ovf && (rd != 5'd0);
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_res"},   out_res,   e.res);
    check({tag, "_rd"},    out_rd,    e.rd);
    check({tag, "_we"},    out_we,    e.we);
    check({tag, "_flags"}, out_flags, e.flags);
    check({tag, "_ovf"},   ovf_exc,   e.ovf);
    check({tag, "_ill"},   illegal,   e.ill);
  endtask

  // Called at a negedge. Optionally holds in_valid with a follow-up request
  // while the result is stalled.
  task automatic send(input string tag, input logic [31:0] iw, input logic [31:0] a,
                      input logic [31:0] b, input int stall, input logic hold,
                      input logic [31:0] h_iw, input logic [31:0] h_a, input logic [31:0] h_b);
    exp_t e;
    int   n;
    e = model(iw, a, b);
    instr = iw; rs_val = a; rt_val = b; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = hold;
    if (hold) begin
      instr = h_iw; rs_val = h_a; rt_val = h_b;
    end else begin
      rs_val = $urandom; rt_val = $urandom; instr = $urandom;
    end
    check({tag, "_exec_valid"}, out_valid, 1'b0);
    check({tag, "_exec_busy"}, in_ready, 1'b0);
    @(negedge clk);
    check({tag, "_latency"}, out_valid, 1'b1);
    check_out(tag, e);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, out_valid, 1'b1);
      check({tag, "_stall_busy"}, in_ready, 1'b0);
      check_out({tag, "_stall"}, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 1'b0);
    check({tag, "_post_ovf"}, ovf_exc, 1'b0);
    check({tag, "_post_ill"}, illegal, 1'b0);
    check({tag, "_post_ready"}, in_ready, 1'b1);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] f);
    return {6'b0, 5'd1, 5'd2, rd, sh, f};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h7fffffff;
      3:       return 32'h80000000;
      4:       return 32'hffffffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0]  fl [11];
    logic [31:0] iw;
    fl = '{FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR,
           FUNC_SLT, FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_JR};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs_val = '0; rt_val = '0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_res", out_res, 32'h0);
    check("rst_we", out_we, 1'b0);
    check("rst_flags", out_flags, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", in_ready, 1'b1);
    @(negedge clk);

    // ADD overflow trap
    send("add_ovf", rtype(5'd3, 5'd0, FUNC_ADD), 32'h7fffffff, 32'h1, 0, 1'b0, 0, 0, 0);
    // SUB with no borrow
    send("sub", rtype(5'd5, 5'd0, FUNC_SUB), 32'hffffffff, 32'hfffffffe, 0, 1'b0, 0, 0, 0);
    send("sll", rtype(5'd7, 5'd28, FUNC_SLL), 32'hdeadbeef, 32'h0000000a, 0, 1'b0, 0, 0, 0);
    send("sra", rtype(5'd7, 5'd31, FUNC_SRA), 32'h12345678, 32'h80000000, 0, 1'b0, 0, 0, 0);
    // Backpressure with a second request waiting
    send("bp1", rtype(5'd9, 5'd0, FUNC_OR), 32'h00f0, 32'h0f00, 5, 1'b1,
         rtype(5'd10, 5'd0, FUNC_XOR), 32'hffff0000, 32'h0ff00ff0);
    send("bp2", rtype(5'd10, 5'd0, FUNC_XOR), 32'hffff0000, 32'h0ff00ff0, 0, 1'b0, 0, 0, 0);
    send("ill_funct", rtype(5'd4, 5'd0, 6'b111111), 32'h5, 32'h6, 1, 1'b0, 0, 0, 0);
    send("ill_opc", {6'b000010, 5'd1, 5'd2, 5'd4, 5'd0, FUNC_ADD}, 32'h5, 32'h6, 0, 1'b0,
         0, 0, 0);
    send("jr", rtype(5'd0, 5'd0, FUNC_JR), 32'h00400020, 32'h9, 0, 1'b0, 0, 0, 0);
    send("and_r0", rtype(5'd0, 5'd0, FUNC_AND), 32'hffffffff, 32'h1234, 0, 1'b0, 0, 0, 0);

    // Independent spot-checks of the headline cases
    check("const_model_add", 64'(model(rtype(5'd3, 5'd0, FUNC_ADD), 32'h7fffffff, 32'h1)),
          64'({32'h80000000, 5'd3, 1'b0, 4'b0100, 1'b1, 1'b0}));

    // Reset during EXEC discards the instruction
    instr = rtype(5'd6, 5'd0, FUNC_ADD); rs_val = 32'd1; rt_val = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_exec_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_exec_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_exec_quiet", out_valid, 1'b0);
    end

    // Reset while a result is pending drops out_valid at once
    instr = rtype(5'd6, 5'd0, FUNC_ADD); rs_val = 32'd1; rt_val = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_done_pre", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_done_valid", out_valid, 1'b0);
    check("rst_done_res", out_res, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 60; k++) begin
      iw = {6'b0, 5'($urandom), 5'($urandom), 5'($urandom_range(0, 31)),
            5'($urandom), fl[$urandom_range(0, 10)]};
      if ($urandom_range(0, 9) == 0) iw[31:26] = 6'($urandom_range(1, 63));
      if ($urandom_range(0, 9) == 0) iw[5:0] = 6'($urandom);
      send("rand", iw, pick_val(), pick_val(), $urandom_range(0, 2), 1'b0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
